// File: rtl/llc_mem_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | llc_mem_bridge                                                             |
// | LLC line requests <-> word-beat memory bus bridge (write-back and fill).   |
// | Optional: LLC_MEM_BRIDGE_STATS_EN adds read/write completion counters.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module llc_mem_bridge #(
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_BITS      = 64,
  parameter int ADDR_BITS      = 32,
  parameter int LINE_ADDR_BITS = 26
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                llc_mem_req_valid,
  output logic                                llc_mem_req_ready,
  input  logic                                llc_mem_req_hwrite,
  input  logic [LINE_ADDR_BITS-1:0]           llc_mem_req_addr,
  input  logic [WORDS_PER_LINE*WORD_BITS-1:0] llc_mem_req_line,
  output logic                                llc_mem_rsp_valid,
  input  logic                                llc_mem_rsp_ready,
  output logic [WORDS_PER_LINE*WORD_BITS-1:0] llc_mem_rsp_line,
  output logic                                mem_valid,
  input  logic                                mem_ready,
  output logic                                mem_write,
  output logic [ADDR_BITS-1:0]                mem_addr,
  output logic [WORD_BITS-1:0]                mem_wdata,
  input  logic                                mem_rdata_valid,
  input  logic [WORD_BITS-1:0]                mem_rdata
`ifdef LLC_MEM_BRIDGE_STATS_EN
  ,
  output logic [31:0]                         stat_rd_cnt,
  output logic [31:0]                         stat_wr_cnt
`endif
);

  localparam int c_IDX_BITS   = $clog2(WORDS_PER_LINE);
  localparam int c_CNT_BITS   = c_IDX_BITS + 1;
  localparam int c_OFF_BITS   = ADDR_BITS - LINE_ADDR_BITS;
  localparam int c_WORD_BYTES = WORD_BITS / 8;
  localparam logic [c_CNT_BITS-1:0] c_LAST = c_CNT_BITS'(WORDS_PER_LINE - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_WRITE = 2'd1;
  localparam logic [1:0] c_ST_READ  = 2'd2;
  localparam logic [1:0] c_ST_RESP  = 2'd3;

  logic [1:0]                                 r_state;
  logic [c_CNT_BITS-1:0]                      r_cmd_cnt;
  logic [c_CNT_BITS-1:0]                      r_data_cnt;
  logic [LINE_ADDR_BITS-1:0]                  r_addr;
  logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0]   r_line;
  logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0]   r_fill;

  logic [c_IDX_BITS-1:0] w_cmd_idx;
  logic [c_IDX_BITS-1:0] w_data_idx;
  logic                  w_cmd_pending;
  logic [ADDR_BITS-1:0]  w_base;
  logic [ADDR_BITS-1:0]  w_offset;
  logic                  w_cmd_fire;
  logic                  w_rd_fire;
  logic                  w_wr_done;
  logic                  w_rsp_done;

  assign w_cmd_idx  = r_cmd_cnt[c_IDX_BITS-1:0];
  assign w_data_idx = r_data_cnt[c_IDX_BITS-1:0];

  // Counter MSB set means all WORDS_PER_LINE address beats have been issued.
  assign w_cmd_pending = (r_state == c_ST_WRITE) ||
                         ((r_state == c_ST_READ) && !r_cmd_cnt[c_CNT_BITS-1]);

  assign w_base   = {r_addr, {c_OFF_BITS{1'b0}}};
  assign w_offset = ADDR_BITS'(r_cmd_cnt) * ADDR_BITS'(c_WORD_BYTES);

  assign w_cmd_fire = w_cmd_pending && mem_ready;
  assign w_rd_fire  = (r_state == c_ST_READ) && mem_rdata_valid && !r_data_cnt[c_CNT_BITS-1];
  assign w_wr_done  = (r_state == c_ST_WRITE) && mem_ready && (r_cmd_cnt == c_LAST);
  assign w_rsp_done = (r_state == c_ST_RESP) && llc_mem_rsp_ready;

  assign llc_mem_req_ready = (r_state == c_ST_IDLE);
  assign llc_mem_rsp_valid = (r_state == c_ST_RESP);
  assign llc_mem_rsp_line  = r_fill;
  assign mem_valid         = w_cmd_pending;
  assign mem_write         = (r_state == c_ST_WRITE);
  assign mem_addr          = w_cmd_pending ? (w_base + w_offset) : '0;
  assign mem_wdata         = (r_state == c_ST_WRITE) ? r_line[w_cmd_idx] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_ST_IDLE;
      r_cmd_cnt  <= '0;
      r_data_cnt <= '0;
      r_addr     <= '0;
      r_line     <= '0;
      r_fill     <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (llc_mem_req_valid) begin
            r_addr     <= llc_mem_req_addr;
            r_line     <= llc_mem_req_line;
            r_cmd_cnt  <= '0;
            r_data_cnt <= '0;
            r_state    <= llc_mem_req_hwrite ? c_ST_WRITE : c_ST_READ;
          end
        end
        c_ST_WRITE: begin
          if (w_cmd_fire) begin
            r_cmd_cnt <= r_cmd_cnt + c_CNT_BITS'(1);
            if (w_wr_done) begin
              r_state <= c_ST_IDLE;
            end
          end
        end
        c_ST_READ: begin
          // Address beats may run ahead of returning data; both sides advance independently.
          if (w_cmd_fire) begin
            r_cmd_cnt <= r_cmd_cnt + c_CNT_BITS'(1);
          end
          if (w_rd_fire) begin
            r_fill[w_data_idx] <= mem_rdata;
            r_data_cnt         <= r_data_cnt + c_CNT_BITS'(1);
            if (r_data_cnt == c_LAST) begin
              r_state <= c_ST_RESP;
            end
          end
        end
        c_ST_RESP: begin
          if (llc_mem_rsp_ready) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

`ifdef LLC_MEM_BRIDGE_STATS_EN
  logic [31:0] r_stat_rd_cnt;
  logic [31:0] r_stat_wr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_rd_cnt <= '0;
      r_stat_wr_cnt <= '0;
    end else begin
      if (w_rsp_done) begin
        r_stat_rd_cnt <= r_stat_rd_cnt + 32'd1;
      end
      if (w_wr_done) begin
        r_stat_wr_cnt <= r_stat_wr_cnt + 32'd1;
      end
    end
  end

  assign stat_rd_cnt = r_stat_rd_cnt;
  assign stat_wr_cnt = r_stat_wr_cnt;
`endif

  // Returned read words are only meaningful while a fill is being gathered.
  a_no_stray_rdata: assert property (
    @(posedge clk) disable iff (!rst) mem_rdata_valid |-> (r_state == c_ST_READ)
  );

endmodule
`default_nettype wire
